// File: rtl/rv32i_types.sv
// Shared RV32I core types: word type, fetch FSM states, IF packet, NOP encoding.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   // Fetch stage control states
   typedef enum logic [1:0] {
      RESET_WAIT = 2'd0,
      FETCH      = 2'd1,
      HOLD       = 2'd2
   } fetch_state_t;

   // IF portion of the pipeline data packet
   typedef struct packed {
      rv32i_word pc;
      rv32i_word instruction;
   } if_packet_t;

   // addi x0, x0, 0
   localparam rv32i_word NOP_INST = 32'h0000_0013;

   // Instruction addresses are word aligned; low two bits are dropped.
   function automatic rv32i_word align_word(input rv32i_word a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: async reset to RESET_PC, loads either the
// sequential successor or the word-aligned redirect target.
module pc_reg
   import rv32i_types::*;
#(
   parameter rv32i_word RESET_PC = 32'h0000_0060
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              sel_redirect_i,
   input  logic [31:0]       redirect_pc_i,
   output logic [31:0]       pc_o,
   output logic [31:0]       pc_next_o
);

   rv32i_word pc_q;
   rv32i_word pc_d;

   // Next-value mux: redirect target wins over sequential increment
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (sel_redirect_i) begin
         pc_d = align_word(redirect_pc_i);
      end
   end

   // PC state, updated only when the fetch stage requests a load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_PC;
      end else if (load_i) begin
         pc_q <= pc_d;
      end
   end

   assign pc_o      = pc_q;
   assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// port and delivers {pc, instruction} beats to the IF/ID buffer, absorbing
// stalls and EX redirects (wrong-path responses are dropped).
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module fetch_stage
   import rv32i_types::*;
#(
   parameter rv32i_word RESET_PC = 32'h0000_0060
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   input  logic              inst_mem_resp,
   input  logic [31:0]       inst_mem_rdata,
   output logic              inst_mem_read,
   output logic [31:0]       inst_mem_address,
   output logic              out_valid,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_inst
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_discarded
`endif
);

   fetch_state_t state_q;
   logic         read_q;
   rv32i_word    addr_q;
   logic         out_valid_q;
   if_packet_t   out_q;
   if_packet_t   hold_q;
   logic         discard_q;

   rv32i_word    pc;
   rv32i_word    pc_next;
   logic         fetch_fire;
   logic         accept;
   logic         beat;
   logic         slot_free;

   assign fetch_fire = (state_q == FETCH) && inst_mem_resp;
   // A response that is kept (not wrong-path) advances the PC
   assign accept     = fetch_fire && !discard_q && !redirect;
   assign beat       = out_valid_q && !stall;
   assign slot_free  = !out_valid_q || !stall;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk            (clk),
      .rst            (rst),
      .load_i         (redirect || accept),
      .sel_redirect_i (redirect),
      .redirect_pc_i  (redirect_pc),
      .pc_o           (pc),
      .pc_next_o      (pc_next)
   );

   // Fetch FSM with registered memory request, discard flag, hold and output slots
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RESET_WAIT;
         read_q      <= 1'b0;
         addr_q      <= RESET_PC;
         out_valid_q <= 1'b0;
         out_q       <= '{pc: RESET_PC, instruction: NOP_INST};
         hold_q      <= '{pc: RESET_PC, instruction: NOP_INST};
         discard_q   <= 1'b0;
      end else begin
         case (state_q)
            RESET_WAIT: begin
               state_q <= FETCH;
               read_q  <= 1'b1;
               addr_q  <= redirect ? pc_next : pc;
            end
            FETCH: begin
               if (redirect) begin
                  out_valid_q <= 1'b0;
                  if (inst_mem_resp) begin
                     // Response in the redirect cycle is wrong-path; the
                     // request slot is free, so start the target right away
                     discard_q <= 1'b0;
                     addr_q    <= pc_next;
                  end else begin
                     // Old request still outstanding: keep its address and
                     // drop exactly one response when it arrives
                     discard_q <= 1'b1;
                  end
               end else begin
                  if (beat) begin
                     out_valid_q <= 1'b0;
                  end
                  if (inst_mem_resp) begin
                     if (discard_q) begin
                        discard_q <= 1'b0;
                        addr_q    <= pc;
                     end else if (slot_free) begin
                        out_q       <= '{pc: addr_q, instruction: inst_mem_rdata};
                        out_valid_q <= 1'b1;
                        addr_q      <= pc_next;
                     end else begin
                        hold_q  <= '{pc: addr_q, instruction: inst_mem_rdata};
                        state_q <= HOLD;
                        read_q  <= 1'b0;
                     end
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  out_valid_q <= 1'b0;
                  state_q     <= FETCH;
                  read_q      <= 1'b1;
                  addr_q      <= pc_next;
               end else if (!stall) begin
                  // Output slot drains this cycle; refill it from hold
                  out_q   <= hold_q;
                  state_q <= FETCH;
                  read_q  <= 1'b1;
                  addr_q  <= pc;
               end
            end
            default: begin
               state_q <= RESET_WAIT;
               read_q  <= 1'b0;
            end
         endcase
      end
   end

   assign inst_mem_read    = read_q;
   assign inst_mem_address = addr_q;
   assign out_valid        = out_valid_q;
   assign out_pc           = out_q.pc;
   assign out_inst         = out_q.instruction;

`ifdef FETCH_PERF_EN
   rv32i_word perf_fetched_q;
   rv32i_word perf_discarded_q;
   logic      dropped;

   assign dropped = fetch_fire && (redirect || discard_q);

   // Free-running event counters for accepted beats and dropped responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q   <= '0;
         perf_discarded_q <= '0;
      end else begin
         if (beat) begin
            perf_fetched_q <= perf_fetched_q + 32'd1;
         end
         if (dropped) begin
            perf_discarded_q <= perf_discarded_q + 32'd1;
         end
      end
   end

   assign perf_fetched   = perf_fetched_q;
   assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: variable-latency memory, a
// transaction-level reference model and directed stimulus.
module tb_fetch_stage;
   import rv32i_types::*;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   logic      stall = 1'b0;
   logic      redirect = 1'b0;
   rv32i_word redirect_pc = '0;
   logic      inst_mem_resp;
   rv32i_word inst_mem_rdata;
   logic      inst_mem_read;
   rv32i_word inst_mem_address;
   logic      out_valid;
   rv32i_word out_pc;
   rv32i_word out_inst;
`ifdef FETCH_PERF_EN
   rv32i_word perf_fetched;
   rv32i_word perf_discarded;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int lat = 1;
   int wait_cnt = 0;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC (32'h0000_0060)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .redirect         (redirect),
      .redirect_pc      (redirect_pc),
      .inst_mem_resp    (inst_mem_resp),
      .inst_mem_rdata   (inst_mem_rdata),
      .inst_mem_read    (inst_mem_read),
      .inst_mem_address (inst_mem_address),
      .out_valid        (out_valid),
      .out_pc           (out_pc),
      .out_inst         (out_inst)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched     (perf_fetched),
      .perf_discarded   (perf_discarded)
`endif
   );

   // Memory contents: a known word at 0x60, address-derived words elsewhere
   function automatic rv32i_word mem_word(input rv32i_word a);
      if (a == 32'h0000_0060) return 32'h00A0_0093;
      return {a[15:0], 16'h0413};
   endfunction

   // Memory answers in the lat-th cycle of a request
   assign inst_mem_resp  = !rst && inst_mem_read && (wait_cnt >= lat - 1);
   assign inst_mem_rdata = mem_word(inst_mem_address);

   always @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= 0;
      else if (inst_mem_read && !inst_mem_resp) wait_cnt <= wait_cnt + 1;
      else wait_cnt <= 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_valid(input int max_cycles);
      int n = 0;
      while (out_valid !== 1'b1 && n < max_cycles) begin
         step(1);
         n++;
      end
      check("wait_valid_timeout", {31'b0, out_valid}, 32'd1);
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      rv32i_word pc;
      rv32i_word inst;
   } pair_t;

   pair_t     m_out[$];
   pair_t     m_hold[$];
   logic      m_started;
   logic      m_req_active;
   rv32i_word m_req_addr;
   rv32i_word m_pc;
   logic      m_drop;
   int        m_fetched;
   int        m_dropped;

   task automatic model_reset();
      m_out.delete();
      m_hold.delete();
      m_started    = 1'b0;
      m_req_active = 1'b0;
      m_req_addr   = 32'h60;
      m_pc         = 32'h60;
      m_drop       = 1'b0;
      m_fetched    = 0;
      m_dropped    = 0;
   endtask

   task automatic model_step();
      logic  fire;
      logic  mbeat;
      pair_t p;
      if (!m_started) begin
         m_started    = 1'b1;
         m_req_active = 1'b1;
         m_req_addr   = m_pc;
         return;
      end
      fire  = m_req_active && inst_mem_resp;
      mbeat = (m_out.size() != 0) && !stall;
      if (mbeat) m_fetched++;
      if (redirect) begin
         m_pc = redirect_pc & ~32'd3;
         m_out.delete();
         m_hold.delete();
         if (fire) begin
            m_dropped++;
            m_drop = 1'b0;
         end
         if (m_req_active && !fire) begin
            m_drop = 1'b1;
         end else begin
            m_req_active = 1'b1;
            m_req_addr   = m_pc;
         end
      end else begin
         if (mbeat) void'(m_out.pop_front());
         if (fire) begin
            if (m_drop) begin
               m_drop = 1'b0;
               m_dropped++;
               m_req_addr = m_pc;
            end else begin
               p.pc   = m_req_addr;
               p.inst = mem_word(m_req_addr);
               m_pc   = m_req_addr + 32'd4;
               if (m_out.size() == 0) begin
                  m_out.push_back(p);
                  m_req_addr = m_pc;
               end else begin
                  m_hold.push_back(p);
                  m_req_active = 1'b0;
               end
            end
         end else if (m_hold.size() != 0 && mbeat) begin
            m_out.push_back(m_hold.pop_front());
            m_req_active = 1'b1;
            m_req_addr   = m_pc;
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step();
      end
   end

   // Compare DUT against model on every falling edge out of reset
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            check("mem_read", {31'b0, inst_mem_read}, {31'b0, m_req_active});
            if (m_req_active) check("mem_addr", inst_mem_address, m_req_addr);
            check("out_valid", {31'b0, out_valid}, {31'b0, (m_out.size() != 0)});
            if (m_out.size() != 0) begin
               check("out_pc", out_pc, m_out[0].pc);
               check("out_inst", out_inst, m_out[0].inst);
               if (!stall) $display("beat pc=%h inst=%h", out_pc, out_inst);
            end
`ifdef FETCH_PERF_EN
            check("perf_fetched_model", perf_fetched, m_fetched);
            check("perf_discarded_model", perf_discarded, m_dropped);
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      step(2);
      check("rst_read", {31'b0, inst_mem_read}, 32'd0);
      check("rst_addr", inst_mem_address, 32'h60);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'h60);
      check("rst_out_inst", out_inst, 32'h13);

      // Reset release and first fetch with a 1-cycle memory
      rst = 1'b0;
      step(1);
      check("first_read", {31'b0, inst_mem_read}, 32'd1);
      check("first_addr", inst_mem_address, 32'h60);
      step(1);
      check("first_valid", {31'b0, out_valid}, 32'd1);
      check("first_pc", out_pc, 32'h60);
      check("first_inst", out_inst, 32'h00A0_0093);
      check("addr_64", inst_mem_address, 32'h64);
      step(1);
      check("addr_68", inst_mem_address, 32'h68);
      check("pc_64", out_pc, 32'h64);

      // Stall for three cycles: output held, next response parked in hold
      stall = 1'b1;
      step(1);
      check("stall_read", {31'b0, inst_mem_read}, 32'd0);
      check("stall_pc1", out_pc, 32'h64);
      step(2);
      check("stall_pc3", out_pc, 32'h64);
      check("stall_valid3", {31'b0, out_valid}, 32'd1);
      stall = 1'b0;
      step(1);
      check("held_pc", out_pc, 32'h68);
      check("resume_addr", inst_mem_address, 32'h6C);
      step(1);
      check("resume_pc", out_pc, 32'h6C);
      step(4);
      check("seq_pc_7c", out_pc, 32'h7C);
      check("seq_addr_80", inst_mem_address, 32'h80);

      // Redirect while the 4-cycle fetch of 0x80 is in flight
      lat   = 4;
      stall = 1'b1;
      step(1);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_1003;
      step(1);
      redirect = 1'b0;
      stall    = 1'b0;
      check("redir_valid", {31'b0, out_valid}, 32'd0);
      check("redir_keep_addr", inst_mem_address, 32'h80);
      step(2);
      check("redir_target_addr", inst_mem_address, 32'h1000);
      check("redir_no_valid", {31'b0, out_valid}, 32'd0);
      wait_valid(10);
      check("redir_pc", out_pc, 32'h1000);
      check("redir_inst", out_inst, 32'h1000_0413);

      // Redirect coinciding with a response and a stall
      lat         = 1;
      stall       = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_2000;
      step(1);
      redirect = 1'b0;
      stall    = 1'b0;
      check("simul_addr", inst_mem_address, 32'h2000);
      check("simul_valid", {31'b0, out_valid}, 32'd0);
      step(1);
      check("simul_pc", out_pc, 32'h2000);
      check("simul_valid2", {31'b0, out_valid}, 32'd1);

      // PC wrap through the top of the address space (unaligned target)
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      step(1);
      redirect = 1'b0;
      check("wrap_addr_top", inst_mem_address, 32'hFFFF_FFFC);
      step(1);
      check("wrap_pc_top", out_pc, 32'hFFFF_FFFC);
      check("wrap_addr_zero", inst_mem_address, 32'h0);
      step(1);
      check("wrap_pc_zero", out_pc, 32'h0);

      // Mixed stall / redirect / latency pattern, checked by the model
      for (int i = 0; i < 48; i++) begin
         stall       = (i % 5 == 2) || (i % 7 == 3);
         redirect    = (i == 13) || (i == 30) || (i == 31);
         redirect_pc = 32'h0000_4001 + 32'(i * 16);
         lat         = 1 + (i / 8) % 3;
         step(1);
      end
      redirect = 1'b0;
      stall    = 1'b0;
      lat      = 1;

      // Reset mid-fetch, then 10 accepted beats and 2 in-flight redirects
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      step(12);
      stall       = 1'b1;
      lat         = 3;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      step(1);
      redirect = 1'b0;
      step(2);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0400;
      step(1);
      redirect = 1'b0;
      step(6);
      check("end_valid", {31'b0, out_valid}, 32'd1);
      check("end_pc", out_pc, 32'h400);
`ifdef FETCH_PERF_EN
      check("perf_fetched", perf_fetched, 32'd10);
      check("perf_discarded", perf_discarded, 32'd2);
`endif
      stall = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
